serial_adder_core: RTL and testbench

Parametrised multi-bit successor to the single-bit half-adder datapath. It adds or subtracts two WIDTH-bit operands in bit-serial or digit-serial form, processing DIGIT bits per clock. Operands and results move through valid/ready handshakes. Results include sum, carry/borrow-out and signed overflow. It sits behind the tt_um top level, with operands and results multiplexed onto ui_in/uio/uo_out by the wrapper.

---
 rtl/serial_adder_core_if.sv | 31 +++
 rtl/serial_adder_core.sv | 130 +++++++++++++
 tb/tb_serial_adder_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_core_if.sv
// Operand/result handshake bundle for serial_adder_core.
// No storage; pure wiring between producer/consumer and the core.
// Operands use in_valid/in_ready, results use out_valid/out_ready.
interface serial_adder_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    // Side that supplies operands and consumes results.
    modport master (
        output in_valid, op_a, op_b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    // The adder core itself.
    modport slave (
        input  in_valid, op_a, op_b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/serial_adder_core.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per clock.
// Latency: result valid WIDTH/DIGIT cycles after the operand acceptance edge.
// Backpressure: result held in DONE until out_ready; operands only taken in IDLE.
module serial_adder_core #(
    parameter int WIDTH = 8,   // >= 2
    parameter int DIGIT = 1    // must divide WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_core_if.slave io
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // effective B (inverted for subtract)
    logic [WIDTH-1:0] acc_q, acc_d;   // partial sum, filled from the MSB side
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;  // operand sign bits, lost from the shifters
    logic             b_msb_q, b_msb_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_next;

    // One digit of the ripple: low DIGIT bits of A, effective B and carry.
    always_comb begin
        dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
        acc_next = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
    end

    // Next-state and datapath control; result registers only move entering DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    state_d = RUN;
                    a_d     = io.op_a;
                    b_d     = io.sub ? ~io.op_b : io.op_b;
                    carry_d = io.sub ? ~io.cin : io.cin;
                    sub_d   = io.sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    a_msb_d = io.op_a[WIDTH-1];
                    b_msb_d = io.sub ? ~io.op_b[WIDTH-1] : io.op_b[WIDTH-1];
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = acc_next;
                    // Subtract carries out as "no borrow", so invert it back.
                    cout_d  = sub_q ^ dsum[DIGIT];
                    // With B already inverted for subtract, one sign rule covers both.
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder_core.sv
// Bench for serial_adder_core: directed vectors on an 8/1 instance plus
// random add/sub sweeps on several WIDTH/DIGIT configurations.
module tb_serial_adder_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sw = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   sw_done [5];

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        bit          cout;
        bit          ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         s;
        bit         c;
        logic [7:0] es;
        bit         ec;
        bit         eo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract and signed range test.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input bit s, input bit c);
        exp_t e;
        int m, ua, ub, sa, sb, r, sr;
        m  = 1 << w;
        ua = int'(a) & (m - 1);
        ub = int'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r      = ua - ub - int'(c);
            sr     = sa - sb - int'(c);
            e.cout = (r < 0);
        end else begin
            r      = ua + ub + int'(c);
            sr     = sa + sb + int'(c);
            e.cout = (r >= m);
        end
        e.sum = 16'(r & (m - 1));
        e.ovf = (sr >= m / 2) || (sr < -(m / 2));
        return e;
    endfunction

    // ---------------- directed instance: WIDTH=8, DIGIT=1 ----------------
    serial_adder_core_if #(.WIDTH(8)) dif ();
    serial_adder_core #(.WIDTH(8), .DIGIT(1)) u_dut (.clk(clk), .rst(rst), .io(dif.slave));

    exp_t dq[$];
    vec_t vecs[9];

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit c,
                          input logic [7:0] es, input bit ec, input bit eo,
                          input int hold, input string nm);
        exp_t e;
        logic [7:0] prev;
        int lat;
        bit stable;
        e.sum = {8'h00, es}; e.cout = ec; e.ovf = eo;
        dq.push_back(e);
        prev = dif.sum;
        dif.op_a = a; dif.op_b = b; dif.sub = s; dif.cin = c;
        dif.in_valid = 1'b1;
        dif.out_ready = (hold == 0);   // high during RUN must be ignored
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        dif.op_a = ~a; dif.op_b = ~b; dif.sub = ~s; dif.cin = ~c;
        chk({nm, "_busy"}, {31'd0, dif.busy}, 32'd1);
        lat = 0;
        stable = 1'b1;
        while (!dif.out_valid && lat < 100) begin
            if (dif.sum !== prev) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd8);
        chk({nm, "_hold_prev"}, {31'd0, stable}, 32'd1);
        e = dq.pop_front();
        chk({nm, "_sum"}, 32'(dif.sum), 32'(e.sum));
        chk({nm, "_cout"}, {31'd0, dif.cout}, {31'd0, e.cout});
        chk({nm, "_ovf"}, {31'd0, dif.overflow}, {31'd0, e.ovf});
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                dif.in_valid = h[0];
                dif.op_a = 8'($urandom); dif.op_b = 8'($urandom);
                @(posedge clk); #1;
                if (!dif.out_valid || dif.sum !== es || dif.cout !== ec ||
                    dif.overflow !== eo || dif.in_ready) stable = 1'b0;
            end
            dif.in_valid = 1'b0;
            chk({nm, "_backpressure_stable"}, {31'd0, stable}, 32'd1);
            dif.out_ready = 1'b1;
        end
        chk({nm, "_in_ready_in_done"}, {31'd0, dif.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_out_valid_drop"}, {31'd0, dif.out_valid}, 32'd0);
        chk({nm, "_in_ready_rise"}, {31'd0, dif.in_ready}, 32'd1);
        dif.out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};

        dif.in_valid = 1'b0; dif.op_a = '0; dif.op_b = '0;
        dif.sub = 1'b0; dif.cin = 1'b0; dif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst_sw = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("rst_sum", 32'(dif.sum), 32'd0);
        chk("rst_cout", {31'd0, dif.cout}, 32'd0);
        chk("rst_ovf", {31'd0, dif.overflow}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
                   vecs[i].es, vecs[i].ec, vecs[i].eo, 0, $sformatf("vec%0d", i));

        // Result held under backpressure while in_valid pulses.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 20, "bp");

        // Reset in the 4th RUN cycle aborts the operation.
        dif.op_a = 8'h7F; dif.op_b = 8'h01; dif.sub = 1'b0; dif.cin = 1'b0;
        dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", {31'd0, dif.in_ready}, 32'd1);
        chk("abort_busy", {31'd0, dif.busy}, 32'd0);
        chk("abort_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("abort_sum", 32'(dif.sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (dif.out_valid) seen = 1'b1;
        end
        chk("abort_no_result", {31'd0, seen}, 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0, "after_abort");

        for (int k = 0; k < 60000; k++) begin
            if (sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3] && sw_done[4]) break;
            @(posedge clk);
        end
        chk("sweep_complete",
            {27'd0, sw_done[4], sw_done[3], sw_done[2], sw_done[1], sw_done[0]}, 32'h1F);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- random sweep over configurations ----------------
    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int W = (g == 4) ? 16 : 8;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
        localparam int N = W / D;

        serial_adder_core_if #(.WIDTH(W)) sif ();
        serial_adder_core #(.WIDTH(W), .DIGIT(D)) u_sw (.clk(clk), .rst(rst_sw), .io(sif.slave));

        exp_t q[$];

        initial begin
            logic [15:0] a, b, mask;
            bit s, c;
            int lat;
            exp_t e;
            sif.in_valid = 1'b0; sif.op_a = '0; sif.op_b = '0;
            sif.sub = 1'b0; sif.cin = 1'b0; sif.out_ready = 1'b0;
            mask = 16'((32'd1 << W) - 1);
            wait (rst_sw == 1'b0);
            @(posedge clk); #1;
            for (int i = 0; i < 200; i++) begin
                a = 16'($urandom) & mask;
                b = 16'($urandom) & mask;
                if (i % 16 == 0) a = mask;
                if (i % 16 == 1) b = mask;
                s = 1'($urandom);
                c = 1'($urandom);
                q.push_back(model(W, a, b, s, c));
                sif.op_a = a[W-1:0]; sif.op_b = b[W-1:0]; sif.sub = s; sif.cin = c;
                sif.in_valid = 1'b1;
                @(posedge clk); #1;
                sif.in_valid = 1'b0;
                lat = 0;
                while (!sif.out_valid && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("sw%0d_latency", g), 32'(lat), 32'(N));
                e = q.pop_front();
                chk($sformatf("sw%0d_sum", g), 32'(sif.sum), 32'(e.sum & mask));
                chk($sformatf("sw%0d_cout", g), {31'd0, sif.cout}, {31'd0, e.cout});
                chk($sformatf("sw%0d_ovf", g), {31'd0, sif.overflow}, {31'd0, e.ovf});
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 sif.out_ready = 1'b1;
                @(posedge clk); #1;
                sif.out_ready = 1'b0;
                chk($sformatf("sw%0d_release", g), {31'd0, sif.in_ready}, 32'd1);
            end
            sw_done[g] = 1'b1;
        end
    end
endmodule
